div_pipe_16by8: RTL

- Iterative restoring divider, the inverse companion of the team's pipelined 8-bit shift-add multiplier.
- Divides a 2*size-bit dividend by a size-bit divisor and returns the quotient and remainder.
- Uses the same en_in/en_out valid style as the multiplier so the two can sit side by side in the datapath, e.g. for multiply/divide round-trip checks.
- Single operation in flight; exposes a ready flag for back-pressure.

---
 rtl/div_pipe_16by8.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/div_pipe_16by8.sv
// Iterative restoring divider: 2*size-bit unsigned dividend by size-bit
// unsigned divisor. One quotient bit per clock, one operation in flight,
// en_in/en_out valid handshake matching the shift-add multiplier.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for div_en_in; div_ready high
// CALC  | one restoring step per edge; last step loads quot/rem/div_zero
module div_pipe_16by8 #(
    parameter int size = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                div_en_in,
    input  logic [2*size-1:0]   div_a,
    input  logic [size-1:0]     div_b,
    output logic                div_ready,
    output logic                div_en_out,
    output logic [2*size-1:0]   quot,
    output logic [size-1:0]     rem,
    output logic                div_zero
);

    localparam int ITER = 2 * size;
    localparam int CW   = $clog2(ITER);
    localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [2*size-1:0] r_dvd;      // dividend, shifted left one bit per step
    logic [size-1:0]   r_dvd_lo;   // original low dividend byte, remainder on divide-by-zero
    logic [size-1:0]   r_dvs;      // divisor
    logic [size-1:0]   r_rem;      // partial remainder (always < divisor)
    logic [2*size-1:0] r_quo;      // quotient being assembled
    logic [CW-1:0]     r_cnt;      // iteration counter
    logic              r_zero;     // divisor was zero

    logic              w_accept;
    logic              w_last;
    logic [size:0]     w_r_sh;
    logic              w_ge;
    logic [size-1:0]   w_r_nxt;
    logic [2*size-1:0] w_q_nxt;

    // Handshake qualifiers derived from the current state.
    always_comb begin
        div_ready = (r_state == IDLE);
        w_accept  = (r_state == IDLE) && div_en_in;
        w_last    = (r_state == CALC) && (r_cnt == LAST_CNT);
    end

    // One restoring step: shift in the next dividend bit, trial subtract.
    // The shifted remainder is size+1 bits wide, but any accepted difference
    // is below the divisor, so the subtraction can be done in size bits.
    always_comb begin
        w_r_sh  = {r_rem, r_dvd[2*size-1]};
        w_ge    = (w_r_sh >= {1'b0, r_dvs});
        w_r_nxt = w_ge ? (w_r_sh[size-1:0] - r_dvs) : w_r_sh[size-1:0];
        w_q_nxt = {r_quo[2*size-2:0], w_ge};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; requests arriving during CALC are simply dropped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (div_en_in) begin
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers: capture operands on acceptance, iterate in CALC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dvd    <= '0;
            r_dvd_lo <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_cnt    <= '0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            r_dvd    <= div_a;
            r_dvd_lo <= div_a[size-1:0];
            r_dvs    <= div_b;
            r_rem    <= '0;
            r_quo    <= '0;
            r_cnt    <= '0;
            r_zero   <= (div_b == '0);
        end else if (r_state == CALC) begin
            r_dvd    <= {r_dvd[2*size-2:0], 1'b0};
            r_rem    <= w_r_nxt;
            r_quo    <= w_q_nxt;
            r_cnt    <= r_cnt + CW'(1);
        end
    end

    // Result registers: loaded on the final step and held until the next one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_en_out <= 1'b0;
            quot       <= '0;
            rem        <= '0;
            div_zero   <= 1'b0;
        end else begin
            div_en_out <= 1'b0;
            if (w_last) begin
                div_en_out <= 1'b1;
                div_zero   <= r_zero;
                quot       <= r_zero ? '1 : w_q_nxt;
                rem        <= r_zero ? r_dvd_lo : w_r_nxt;
            end
        end
    end

endmodule
